// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings, opcodes,
// datapath mux-select constants and the raw control bundle.
package multicycle_ctrl_defs;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] SRCA_A    = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  // TST/TEQ/CMP/CMN only set flags, so their ALUWB must not touch the reg file.
  function automatic logic is_no_write(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] cmd;
    cmd = funct[4:1];
    return (op == OP_DP) && (cmd inside {4'b1000, 4'b1001, 4'b1010, 4'b1011});
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational state -> raw control table for the multicycle control FSM.
// Unlisted states (including TRAP) drive every control low.
module multicycle_ctrl_decode
  import multicycle_ctrl_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = 1'b0;
        ctrl.result_src = RES_ALURES;
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALURES;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle datapath: state register, next-state
// logic and cond_ex/no_write write gating. MULTICYCLE_FSM_ILLEGAL_TRAP_EN adds
// the TRAP state and the illegal_op output.
//
// state    | meaning
// FETCH    | load IR from memory[PC], PC <= PC+4
// DECODE   | read operands, ALU precomputes PC+8
// MEMADR   | compute load/store address
// MEMRD    | read data memory into data register
// MEMWB    | write loaded data to register file
// MEMWR    | write B register to data memory
// EXECUTER | ALU op with register operand
// EXECUTEI | ALU op with immediate operand
// ALUWB    | write ALUOut to register file
// BRANCH   | PC <= branch target when cond_ex
// TRAP     | illegal opcode, parked until reset
module multicycle_control_fsm
  import multicycle_ctrl_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset_synchronous,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       cond_ex,
  output logic       pc_write_en,
  output logic       ir_write_en,
  output logic       reg_write_en,
  output logic       mem_write_en,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_op,
  output logic [1:0] result_src
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] dec_state;
  ctrl_t              ctrl;
  logic               no_write;

  always_ff @(posedge clk) begin
    if (reset_synchronous) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_MEM:  state <= S_MEMADR;
            OP_DP:   state <= funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_BR:   state <= S_BRANCH;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
            default: state <= S_TRAP;
`else
            default: state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR:   state <= funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state <= S_MEMWB;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
        S_TRAP:     state <= S_TRAP;
`endif
        default:    state <= S_FETCH;
      endcase
    end
  end

  // During reset the mux selects already present FETCH values.
  assign dec_state = reset_synchronous ? S_FETCH : state;

  multicycle_ctrl_decode #(
    .STATE_W (STATE_W)
  ) u_decode (
    .state (dec_state),
    .ctrl  (ctrl)
  );

  assign no_write = is_no_write(op, funct);

  assign pc_write_en  = ~reset_synchronous & (ctrl.next_pc | (ctrl.branch & cond_ex));
  assign ir_write_en  = ~reset_synchronous & ctrl.ir_write;
  assign reg_write_en = ~reset_synchronous & ctrl.reg_w & cond_ex & ~no_write;
  assign mem_write_en = ~reset_synchronous & ctrl.mem_w & cond_ex;
  assign adr_src      = ctrl.adr_src;
  assign alu_src_a    = ctrl.alu_src_a;
  assign alu_src_b    = ctrl.alu_src_b;
  assign alu_op       = ctrl.alu_op;
  assign result_src   = ctrl.result_src;

`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
  assign illegal_op = ~reset_synchronous & (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm; honours MULTICYCLE_FSM_ILLEGAL_TRAP_EN.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset_synchronous;
  logic [1:0] op;
  logic [5:0] funct;
  logic       cond_ex;
  logic       pc_write_en, ir_write_en, reg_write_en, mem_write_en;
  logic       adr_src, alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk               (clk),
    .reset_synchronous (reset_synchronous),
    .op                (op),
    .funct             (funct),
    .cond_ex           (cond_ex),
    .pc_write_en       (pc_write_en),
    .ir_write_en       (ir_write_en),
    .reg_write_en      (reg_write_en),
    .mem_write_en      (mem_write_en),
    .adr_src           (adr_src),
    .alu_src_a         (alu_src_a),
    .alu_src_b         (alu_src_b),
    .alu_op            (alu_op),
    .result_src        (result_src)
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
    ,
    .illegal_op        (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] o, input logic [5:0] f, input logic c);
    op = o;
    funct = f;
    cond_ex = c;
  endtask

  task automatic test_reset();
    reset_synchronous = 1'b1;
    set_instr(2'b00, 6'b000000, 1'b1);
    step();
    step();
    checks++; if (ir_write_en !== 1'b0) begin errors++; $display("FAIL rst_ir got %0b exp 0", ir_write_en); end
    checks++; if (pc_write_en !== 1'b0) begin errors++; $display("FAIL rst_pc got %0b exp 0", pc_write_en); end
    checks++; if (alu_src_b !== 2'b10) begin errors++; $display("FAIL rst_srcb got %0b exp 10", alu_src_b); end
    checks++; if (result_src !== 2'b10) begin errors++; $display("FAIL rst_res got %0b exp 10", result_src); end
    reset_synchronous = 1'b0;
    #1;
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL rst_rel_ir got %0b exp 1", ir_write_en); end
    checks++; if (pc_write_en !== 1'b1) begin errors++; $display("FAIL rst_rel_pc got %0b exp 1", pc_write_en); end
    // reset in the middle of a data-processing instruction
    set_instr(2'b00, 6'b001000, 1'b1);
    step();
    step();
    checks++; if (alu_op !== 1'b1) begin errors++; $display("FAIL rst_mid_exec_aluop got %0b exp 1", alu_op); end
    reset_synchronous = 1'b1;
    #1;
    checks++; if (alu_src_b !== 2'b10) begin errors++; $display("FAIL rst_mid_srcb got %0b exp 10", alu_src_b); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL rst_mid_reg got %0b exp 0", reg_write_en); end
    step();
    checks++; if (ir_write_en !== 1'b0) begin errors++; $display("FAIL rst_hold_ir got %0b exp 0", ir_write_en); end
    checks++; if (alu_src_a !== 2'b01) begin errors++; $display("FAIL rst_hold_srca got %0b exp 01", alu_src_a); end
    step();
    reset_synchronous = 1'b0;
    #1;
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL rst_mid_rel_ir got %0b exp 1", ir_write_en); end
    checks++; if (alu_op !== 1'b0) begin errors++; $display("FAIL rst_mid_rel_aluop got %0b exp 0", alu_op); end
  endtask

  task automatic test_add_reg();
    set_instr(2'b00, 6'b001000, 1'b1);
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL add_c1_reg got %0b exp 0", reg_write_en); end
    step();
    checks++; if (ir_write_en !== 1'b0) begin errors++; $display("FAIL add_c2_ir got %0b exp 0", ir_write_en); end
    checks++; if (pc_write_en !== 1'b0) begin errors++; $display("FAIL add_c2_pc got %0b exp 0", pc_write_en); end
    step();
    checks++; if (alu_src_b !== 2'b00) begin errors++; $display("FAIL add_c3_srcb got %0b exp 00", alu_src_b); end
    checks++; if (alu_op !== 1'b1) begin errors++; $display("FAIL add_c3_aluop got %0b exp 1", alu_op); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL add_c3_reg got %0b exp 0", reg_write_en); end
    step();
    checks++; if (reg_write_en !== 1'b1) begin errors++; $display("FAIL add_c4_reg got %0b exp 1", reg_write_en); end
    checks++; if (result_src !== 2'b00) begin errors++; $display("FAIL add_c4_res got %0b exp 00", result_src); end
    step();
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL add_next_ir got %0b exp 1", ir_write_en); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL add_next_reg got %0b exp 0", reg_write_en); end
  endtask

  task automatic test_add_imm();
    set_instr(2'b00, 6'b101000, 1'b1);
    step();
    step();
    checks++; if (alu_src_b !== 2'b01) begin errors++; $display("FAIL addi_c3_srcb got %0b exp 01", alu_src_b); end
    checks++; if (alu_op !== 1'b1) begin errors++; $display("FAIL addi_c3_aluop got %0b exp 1", alu_op); end
    step();
    checks++; if (reg_write_en !== 1'b1) begin errors++; $display("FAIL addi_c4_reg got %0b exp 1", reg_write_en); end
    step();
  endtask

  task automatic test_ldr();
    set_instr(2'b01, 6'b000001, 1'b1);
    step();
    step();
    checks++; if (alu_src_b !== 2'b01) begin errors++; $display("FAIL ldr_c3_srcb got %0b exp 01", alu_src_b); end
    checks++; if (alu_src_a !== 2'b00) begin errors++; $display("FAIL ldr_c3_srca got %0b exp 00", alu_src_a); end
    step();
    checks++; if (adr_src !== 1'b1) begin errors++; $display("FAIL ldr_c4_adr got %0b exp 1", adr_src); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL ldr_c4_reg got %0b exp 0", reg_write_en); end
    step();
    checks++; if (result_src !== 2'b01) begin errors++; $display("FAIL ldr_c5_res got %0b exp 01", result_src); end
    checks++; if (reg_write_en !== 1'b1) begin errors++; $display("FAIL ldr_c5_reg got %0b exp 1", reg_write_en); end
    step();
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL ldr_next_ir got %0b exp 1", ir_write_en); end
  endtask

  task automatic test_str(input logic c, input logic exp_mw);
    set_instr(2'b01, 6'b000000, c);
    step();
    step();
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL str_c3_mem got %0b exp 0", mem_write_en); end
    step();
    checks++; if (mem_write_en !== exp_mw) begin errors++; $display("FAIL str_c4_mem got %0b exp %0b", mem_write_en, exp_mw); end
    checks++; if (adr_src !== 1'b1) begin errors++; $display("FAIL str_c4_adr got %0b exp 1", adr_src); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL str_c4_reg got %0b exp 0", reg_write_en); end
    step();
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL str_next_ir got %0b exp 1", ir_write_en); end
    checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL str_next_mem got %0b exp 0", mem_write_en); end
  endtask

  task automatic test_cmp();
    set_instr(2'b00, 6'b010101, 1'b1);
    step();
    step();
    checks++; if (alu_op !== 1'b1) begin errors++; $display("FAIL cmp_c3_aluop got %0b exp 1", alu_op); end
    step();
    checks++; if (alu_op !== 1'b0) begin errors++; $display("FAIL cmp_c4_aluop got %0b exp 0", alu_op); end
    checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL cmp_c4_reg got %0b exp 0", reg_write_en); end
    step();
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL cmp_next_ir got %0b exp 1", ir_write_en); end
  endtask

  task automatic test_branch(input logic c);
    set_instr(2'b10, 6'b000000, c);
    checks++; if (pc_write_en !== 1'b1) begin errors++; $display("FAIL br_c1_pc got %0b exp 1", pc_write_en); end
    step();
    checks++; if (pc_write_en !== 1'b0) begin errors++; $display("FAIL br_c2_pc got %0b exp 0", pc_write_en); end
    step();
    checks++; if (pc_write_en !== c) begin errors++; $display("FAIL br_c3_pc got %0b exp %0b", pc_write_en, c); end
    checks++; if (alu_src_b !== 2'b01) begin errors++; $display("FAIL br_c3_srcb got %0b exp 01", alu_src_b); end
    checks++; if (result_src !== 2'b10) begin errors++; $display("FAIL br_c3_res got %0b exp 10", result_src); end
    step();
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL br_c4_ir got %0b exp 1", ir_write_en); end
  endtask

  task automatic test_op11();
    set_instr(2'b11, 6'b000000, 1'b1);
    step();
    step();
`ifdef MULTICYCLE_FSM_ILLEGAL_TRAP_EN
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL trap_c3_ill got %0b exp 1", illegal_op); end
    checks++; if (ir_write_en !== 1'b0) begin errors++; $display("FAIL trap_c3_ir got %0b exp 0", ir_write_en); end
    step();
    step();
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL trap_hold_ill got %0b exp 1", illegal_op); end
    checks++; if (pc_write_en !== 1'b0) begin errors++; $display("FAIL trap_hold_pc got %0b exp 0", pc_write_en); end
    reset_synchronous = 1'b1;
    step();
    reset_synchronous = 1'b0;
    #1;
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL trap_rst_ill got %0b exp 0", illegal_op); end
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL trap_rst_ir got %0b exp 1", ir_write_en); end
`else
    checks++; if (ir_write_en !== 1'b1) begin errors++; $display("FAIL nop_c3_ir got %0b exp 1", ir_write_en); end
    checks++; if (pc_write_en !== 1'b1) begin errors++; $display("FAIL nop_c3_pc got %0b exp 1", pc_write_en); end
`endif
  endtask

  initial begin
    test_reset();
    test_add_reg();
    test_add_imm();
    test_ldr();
    test_str(1'b1, 1'b1);
    test_str(1'b0, 1'b0);
    test_cmp();
    test_branch(1'b1);
    test_branch(1'b0);
    test_op11();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
